muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
// - Iterative multiply/divide unit sitting downstream of the regfile read ports (src_a/src_b = r1_data/r2_data).
// - Writes its result back through the regfile write port (wdata/waddr/rw_/byte_en), one full word per op.
// - Handles MUL, MULH, DIV and REM in a fixed BITS+2 cycle latency, so the core can stall on busy.
// PARAMETERS
// - BITS       REG_NUM_BITS (32)             datapath / register width
// - ADDR_LEFT  $clog2(REG_NUM_WORDS)-1 (4)   MSB of destination register address
// PORTS
// - clk         in   1            system clock
// - rst_        in   1            asynchronous active-low reset
// - start       in   1            op request; accepted only when ready=1
// - op          in   2            00 MUL(lo), 01 MULH(hi), 10 DIV(quotient), 11 REM(remainder)
// - op_signed   in   1            signed operands (used only with MULDIV_SIGNED_EN)
// - rd          in   ADDR_LEFT+1  destination register
// - src_a       in   BITS         operand A / dividend (from r1_data)
// - src_b       in   BITS         operand B / divisor  (from r2_data)
// - ready       out  1            unit idle, start will be accepted
// - busy        out  1            op in flight (= !ready)
// - done        out  1            one-cycle pulse, result valid
// - result      out  BITS         last result; holds until next done
// - wb_wdata    out  BITS         to regfile wdata
// - wb_waddr    out  ADDR_LEFT+1  to regfile waddr
// - wb_rw_      out  1            to regfile rw_ (0 = write), low only in WB
// - wb_byte_en  out  4            to regfile byte_en, constant 4'b1111
// BEHAVIOUR
// - Reset (rst_=0, async): state=IDLE, ready=1, busy=0, done=0, result=0, wb_wdata=0, wb_waddr=0, wb_rw_=1, count=0.
// - FSM: IDLE -(start)-> CALC -(count==BITS-1)-> WB -> IDLE. Accept edge = cycle 0.
// - IDLE: on start latch op, op_signed, rd, src_a, src_b; clear accumulator; count=0.
// - CALC: exactly BITS cycles, one bit per cycle.
//   - MUL/MULH: shift-add over 2*BITS product register, LSB of multiplier first.
//   - DIV/REM: restoring divide; shift remainder left, subtract divisor if no borrow, shift quotient bit in.
// - WB: one cycle (cycle BITS+1 after accept): done=1, result/wb_wdata=selected result, wb_waddr=rd, wb_rw_=0.
// - Latency: start accepted at edge 0 -> done high during cycle BITS+1; next start accepted in that WB cycle? No: ready=1 only in IDLE, so earliest next accept is edge BITS+2.
// - start while busy: ignored, no queueing; latched operands unaffected.
// - rd==0: full computation, done pulses, result updated, but wb_rw_ stays 1 (no write to $zero).
// - MUL returns product[BITS-1:0]; MULH returns product[2*BITS-1:BITS]; all arithmetic modulo 2^BITS.
// - Divide by zero: quotient = all ones, remainder = dividend; still BITS+2 cycles.
// - Reset mid-op: op discarded, no writeback, outputs to reset values.
// - Operands sampled only at accept; src_a/src_b may change during CALC.
// CONFIGURATION
// - MULDIV_SIGNED_EN defined: op_signed=1 selects signed ops.
//   - Magnitudes taken at accept, unsigned core runs, sign fixed in WB (no extra cycle).
//   - Product sign = a^b; quotient sign = a^b; remainder sign = dividend sign.
//   - Div by zero: quotient = -1, remainder = dividend.
//   - Overflow -2^(BITS-1) / -1: quotient = -2^(BITS-1), remainder = 0.
// - MULDIV_SIGNED_EN undefined: op_signed ignored, all ops unsigned, sign-fix logic absent.
// TESTING
// - Reset: rst_=0 mid-CALC -> ready=1, done=0, wb_rw_=1, no write seen at regfile; next op runs normally.
// - MUL 7*6, rd=5 -> done at cycle 33, wb_wdata=42, wb_waddr=5, wb_rw_=0 for exactly one cycle, byte_en=4'hF.
// - MULH 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE; MUL same -> 0x0000_0001.
// - DIV 100/7 -> 14, REM 100/7 -> 2; DIV 5/0 -> 0xFFFF_FFFF, REM 5/0 -> 5.
// - start pulsed every cycle while busy and rd=0 op -> only first op accepted, rd=0 gives done but wb_rw_ stays 1.
// - With MULDIV_SIGNED_EN: DIV -7/2 -> 0xFFFF_FFFD (-3), REM -> 0xFFFF_FFFF (-1); DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit. Takes its operands from the
//            regfile read ports and writes one full-word result back through
//            the regfile write port. MUL, MULH, DIV and REM each take a fixed
//            BITS+2 cycles from accept to ready, so the core can stall on busy.
// Options  : MULDIV_SIGNED_EN - when defined, op_signed=1 selects signed ops.
//            Magnitudes are taken at accept and the sign is applied in WB.
// Ports    : clk, rst_ (async active-low)
//            start/op/op_signed/rd/src_a/src_b : op request (taken when ready)
//            ready/busy                         : unit idle / op in flight
//            done/result                        : one-cycle pulse, last result
//            wb_wdata/wb_waddr/wb_rw_/wb_byte_en: regfile write port
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int BITS      = 32,
  parameter int ADDR_LEFT = 4
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 op_signed,
  input  logic [ADDR_LEFT:0]   rd,
  input  logic [BITS-1:0]      src_a,
  input  logic [BITS-1:0]      src_b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [BITS-1:0]      result,
  output logic [BITS-1:0]      wb_wdata,
  output logic [ADDR_LEFT:0]   wb_waddr,
  output logic                 wb_rw_,
  output logic [3:0]           wb_byte_en
);

  localparam int                 c_CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic [1:0]           r_op;
  logic [ADDR_LEFT:0]   r_rd;
  logic [BITS-1:0]      r_mcand;   // multiplicand (MUL*) or divisor (DIV/REM)
  logic [BITS-1:0]      r_hi;      // product high half / partial remainder
  logic [BITS-1:0]      r_lo;      // multiplier -> product low / dividend -> quotient
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_done;
  logic                 r_rw_;
  logic [BITS-1:0]      r_result;
  logic [ADDR_LEFT:0]   r_waddr;

  logic                 w_accept;
  logic                 w_last;
  logic [BITS-1:0]      w_a_mag;
  logic [BITS-1:0]      w_b_mag;
  logic [BITS:0]        w_sum;
  logic [BITS:0]        w_shift;
  logic [BITS:0]        w_diff;
  logic                 w_borrow;
  logic [BITS-1:0]      w_hi_n;
  logic [BITS-1:0]      w_lo_n;
  logic [2*BITS-1:0]    w_prod;
  logic [BITS-1:0]      w_quo;
  logic [BITS-1:0]      w_rem;
  logic [BITS-1:0]      w_sel;

`ifdef MULDIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic w_neg_q;
  logic w_neg_r;
  logic r_neg_q;   // negate product / quotient in WB
  logic r_neg_r;   // negate remainder in WB

  assign w_a_neg = op_signed & src_a[BITS-1];
  assign w_b_neg = op_signed & src_b[BITS-1];
  assign w_a_mag = w_a_neg ? -src_a : src_a;
  assign w_b_mag = w_b_neg ? -src_b : src_b;
  // A zero divisor must leave the all-ones quotient untouched (i.e. -1).
  assign w_neg_q = (w_a_neg ^ w_b_neg) & (~op[1] | (src_b != '0));
  assign w_neg_r = w_a_neg;
`else
  logic unused_op_signed;
  assign unused_op_signed = op_signed;
  assign w_a_mag = src_a;
  assign w_b_mag = src_b;
`endif

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_CALC) && (r_cnt == c_LAST);

  // One iteration of either algorithm.
  // Shift-add: add multiplicand when multiplier LSB is set, then shift the
  // whole {carry, hi, lo} right by one.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  // Restoring divide: the partial remainder stays below the divisor, so the
  // shifted value fits BITS+1 bits and bit BITS of the difference is the borrow.
  // A zero divisor never borrows: quotient all ones, remainder = dividend.
  assign w_shift  = {r_hi, r_lo[BITS-1]};
  assign w_diff   = w_shift - {1'b0, r_mcand};
  assign w_borrow = w_diff[BITS];

  always_comb begin
    w_hi_n = w_sum[BITS:1];
    w_lo_n = {w_sum[0], r_lo[BITS-1:1]};
    if (r_op[1]) begin
      w_hi_n = w_borrow ? w_shift[BITS-1:0] : w_diff[BITS-1:0];
      w_lo_n = {r_lo[BITS-2:0], ~w_borrow};
    end
  end

  // Result selection works on the final iteration's values so the registered
  // outputs are valid in the WB cycle itself.
  always_comb begin
    w_prod = {w_hi_n, w_lo_n};
    w_quo  = w_lo_n;
    w_rem  = w_hi_n;
`ifdef MULDIV_SIGNED_EN
    if (r_neg_q) begin
      w_prod = -{w_hi_n, w_lo_n};
      w_quo  = -w_lo_n;
    end
    if (r_neg_r) begin
      w_rem  = -w_hi_n;
    end
`endif
    case (r_op)
      2'b00:   w_sel = w_prod[BITS-1:0];
      2'b01:   w_sel = w_prod[2*BITS-1:BITS];
      2'b10:   w_sel = w_quo;
      default: w_sel = w_rem;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_n = S_CALC;
      S_CALC:  if (r_cnt == c_LAST) w_state_n = S_WB;
      S_WB:    w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_rw_    <= 1'b1;
      r_result <= '0;
      r_waddr  <= '0;
`ifdef MULDIV_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_done <= w_last;
      // Writes to register 0 are suppressed; the op still completes.
      r_rw_  <= ~(w_last && (r_rd != '0));
      if (w_last) begin
        r_result <= w_sel;
        r_waddr  <= r_rd;
      end
      if (w_accept) begin
        r_op    <= op;
        r_rd    <= rd;
        r_mcand <= op[1] ? w_b_mag : w_a_mag;
        r_lo    <= op[1] ? w_a_mag : w_b_mag;
        r_hi    <= '0;
        r_cnt   <= '0;
`ifdef MULDIV_SIGNED_EN
        r_neg_q <= w_neg_q;
        r_neg_r <= w_neg_r;
`endif
      end else if (r_state == S_CALC) begin
        r_hi  <= w_hi_n;
        r_lo  <= w_lo_n;
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign ready      = (r_state == S_IDLE);
  assign busy       = ~ready;
  assign done       = r_done;
  assign result     = r_result;
  assign wb_wdata   = r_result;
  assign wb_waddr   = r_waddr;
  assign wb_rw_     = r_rw_;
  assign wb_byte_en = 4'b1111;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit. Expected results are pushed
//            to a queue when an op is accepted and compared when done pulses.
//            Signed cases are built in only with MULDIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int BITS      = 32;
  localparam int ADDR_LEFT = 4;

  logic                 clk;
  logic                 rst_;
  logic                 start;
  logic [1:0]           op;
  logic                 op_signed;
  logic [ADDR_LEFT:0]   rd;
  logic [BITS-1:0]      src_a;
  logic [BITS-1:0]      src_b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [BITS-1:0]      result;
  logic [BITS-1:0]      wb_wdata;
  logic [ADDR_LEFT:0]   wb_waddr;
  logic                 wb_rw_;
  logic [3:0]           wb_byte_en;

  muldiv_unit #(.BITS(BITS), .ADDR_LEFT(ADDR_LEFT)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .start      (start),
    .op         (op),
    .op_signed  (op_signed),
    .rd         (rd),
    .src_a      (src_a),
    .src_b      (src_b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .wb_wdata   (wb_wdata),
    .wb_waddr   (wb_waddr),
    .wb_rw_     (wb_rw_),
    .wb_byte_en (wb_byte_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BITS-1:0]    res;
    logic [ADDR_LEFT:0] rd;
    int                 acc;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  logic [BITS-1:0] last_exp = '0;
  int              n_vec = 0;
  int              n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BITS-1:0] model(input logic [1:0] o, input logic [BITS-1:0] a,
                                            input logic [BITS-1:0] b, input logic sg);
    logic [2*BITS-1:0] p;
`ifdef MULDIV_SIGNED_EN
    longint sa, sbv, sr;
    if (sg) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (o)
        2'b00, 2'b01: begin
          sr = sa * sbv;
          p  = sr;
          return (o == 2'b00) ? p[BITS-1:0] : p[2*BITS-1:BITS];
        end
        2'b10: begin
          if (b == '0) return '1;
          if (a == 32'h8000_0000 && b == '1) return a;
          sr = sa / sbv;
          p  = sr;
          return p[BITS-1:0];
        end
        default: begin
          if (b == '0) return a;
          if (a == 32'h8000_0000 && b == '1) return '0;
          sr = sa % sbv;
          p  = sr;
          return p[BITS-1:0];
        end
      endcase
    end
`endif
    p = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
    case (o)
      2'b00:   return p[BITS-1:0];
      2'b01:   return p[2*BITS-1:BITS];
      2'b10:   return (b == '0) ? '1 : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_) begin
      if (start && ready) begin
        sb.push_back('{res: model(op, src_a, src_b, op_signed), rd: rd, acc: cyc});
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          mon_e = sb.pop_front();
          check("result",   result,   mon_e.res);
          check("wb_wdata", wb_wdata, mon_e.res);
          check("wb_waddr", wb_waddr, mon_e.rd);
          check("wb_rw_",   wb_rw_,   (mon_e.rd == 0));
          check("byte_en",  wb_byte_en, 4'hF);
          check("latency",  cyc - mon_e.acc, BITS + 1);
          check("busy_wb",  busy, 1);
          last_exp = mon_e.res;
        end
      end else if (!wb_rw_) begin
        check("wb_rw_stray", wb_rw_, 1);
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input logic [ADDR_LEFT:0] d, input logic sg);
    int w = 0;
    @(posedge clk); #1;
    while (!ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!ready) check("ready_timeout", ready, 1);
    start     = 1'b1;
    op        = o;
    src_a     = a;
    src_b     = b;
    rd        = d;
    op_signed = sg;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands are sampled only at accept; scramble them afterwards.
    src_a = $urandom;
    src_b = $urandom;
    rd    = 5'($urandom);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((sb.size() != 0 || !ready) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_      = 1'b0;
    start     = 1'b0;
    op        = 2'b00;
    op_signed = 1'b0;
    rd        = '0;
    src_a     = '0;
    src_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",    ready,    1);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_result",   result,   0);
    check("rst_wdata",    wb_wdata, 0);
    check("rst_waddr",    wb_waddr, 0);
    check("rst_rw_",      wb_rw_,   1);
    check("rst_byte_en",  wb_byte_en, 4'hF);
    @(posedge clk); #1;
    rst_ = 1'b1;

    // Directed vectors
    do_op(2'b00, 32'd7, 32'd6, 5'd5, 1'b0);
    wait_drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("result_hold", result, 32'd42);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    do_op(2'b10, 32'd100, 32'd7, 5'd8, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 5'd9, 1'b0);
    do_op(2'b10, 32'd5, 32'd0, 5'd10, 1'b0);
    do_op(2'b11, 32'd5, 32'd0, 5'd11, 1'b0);
    wait_drain();

    // start held high while busy, rd=0: only the first op is taken
    do_op(2'b00, 32'd3, 32'd4, 5'd0, 1'b0);
    start = 1'b1;
    for (int i = 0; i < BITS; i++) begin
      op    = 2'($urandom);
      src_a = $urandom;
      src_b = $urandom;
      rd    = 5'd7;
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_drain();

    // Reset in the middle of CALC
    do_op(2'b00, 32'd9, 32'd9, 5'd6, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_ = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_ready",  ready,  1);
    check("midrst_done",   done,   0);
    check("midrst_rw_",    wb_rw_, 1);
    check("midrst_result", result, 0);
    @(posedge clk); #1;
    rst_ = 1'b1;
    repeat (40) @(posedge clk);
    do_op(2'b00, 32'd9, 32'd9, 5'd6, 1'b0);
    wait_drain();

`ifdef MULDIV_SIGNED_EN
    do_op(2'b10, -32'sd7, 32'd2, 5'd12, 1'b1);
    do_op(2'b11, -32'sd7, 32'd2, 5'd13, 1'b1);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd16, 1'b1);
    do_op(2'b10, -32'sd5, 32'd0, 5'd17, 1'b1);
    do_op(2'b11, -32'sd5, 32'd0, 5'd18, 1'b1);
    wait_drain();
`endif

    // Random vectors, with small and zero divisors mixed in
    for (int i = 0; i < 24; i++) begin
      logic [BITS-1:0] b;
      b = $urandom;
      case (i % 4)
        0: b = '0;
        1: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op(2'($urandom), $urandom, b, 5'($urandom), 1'($urandom));
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
